// File: rtl/mem_pkg.sv
// Shared cell-memory constants, footer layout and the cell reader state encoding.
package mem_pkg;

  localparam int unsigned BLOCK_BYTES   = 64;
  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned PAYLOAD_BYTES = 62;
  localparam int unsigned BLOCK_BITS    = 512;
  localparam int unsigned FOOTER_BITS   = (BLOCK_BYTES - PAYLOAD_BYTES) * 8;
  // Width of the valid-byte count carried in next_idx of an end-of-packet cell.
  localparam int unsigned CNT_FIELD_W   = 6;

  // Footer occupies the top FOOTER_BITS of a cell: {eop, rsvd, next_idx}.
  typedef struct packed {
    logic              eop;
    logic [2:0]        rsvd;
    logic [ADDR_W-1:0] next_idx;
  } footer_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    STREAM,
    FREE
  } rd_state_t;

endpackage

// File: rtl/cell_reader.sv
// Walks a linked chain of memory cells for one packet, streams the payload
// bytes out, and returns each consumed cell to the free list.
module cell_reader
  import mem_pkg::*;
#(
  parameter int unsigned MAX_CELLS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_head,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [BLOCK_BITS-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  free_valid,
  input  logic                  free_ready,
  output logic [ADDR_W-1:0]     free_idx,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CELLS_W = (MAX_CELLS < 2) ? 1 : $clog2(MAX_CELLS);
  localparam logic [CELLS_W-1:0]     LAST_CELL = CELLS_W'(MAX_CELLS - 1);
  localparam logic [CNT_FIELD_W-1:0] MAX_COUNT = CNT_FIELD_W'(PAYLOAD_BYTES);
  localparam logic [CNT_FIELD_W-1:0] LAST_BYTE = CNT_FIELD_W'(PAYLOAD_BYTES - 1);

  rd_state_t                  state;
  logic [ADDR_W-1:0]          cur_idx;
  logic [ADDR_W-1:0]          next_idx_q;
  logic [CELLS_W-1:0]         cell_cnt;
  logic                       first;
  logic                       term;
  logic [CNT_FIELD_W-1:0]     ptr;
  logic [CNT_FIELD_W-1:0]     last_ptr;
  logic [PAYLOAD_BYTES*8-1:0] line;

  footer_t                    ftr;
  logic [CNT_FIELD_W-1:0]     ftr_cnt;
  logic                       cnt_bad;
  logic                       forced;
  logic                       dec_term;
  logic [CNT_FIELD_W-1:0]     dec_last_ptr;
  logic [CNT_FIELD_W-1:0]     ptr_nxt;
  logic                       unused_rsvd;

  // Footer decode of the cell arriving from memory during WAIT.
  assign ftr          = footer_t'(mem_rd_data[BLOCK_BITS-1 -: FOOTER_BITS]);
  assign ftr_cnt      = ftr.next_idx[CNT_FIELD_W-1:0];
  assign cnt_bad      = (ftr_cnt == '0) || (ftr_cnt > MAX_COUNT);
  assign forced       = !ftr.eop && (cell_cnt == LAST_CELL);
  assign dec_term     = ftr.eop || forced;
  assign dec_last_ptr = (ftr.eop && !cnt_bad) ? ftr_cnt - 1'b1 : LAST_BYTE;
  assign ptr_nxt      = ptr + 1'b1;
  assign unused_rsvd  = ^ftr.rsvd;

  assign busy = (state != IDLE);

  // Packet walk FSM; all handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      free_valid  <= 1'b0;
      free_idx    <= '0;
      err         <= 1'b0;
      cur_idx     <= '0;
      next_idx_q  <= '0;
      cell_cnt    <= '0;
      first       <= 1'b0;
      term        <= 1'b0;
      ptr         <= '0;
      last_ptr    <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cur_idx     <= cmd_head;
            cell_cnt    <= '0;
            first       <= 1'b1;
            cmd_ready   <= 1'b0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= cmd_head;
            state       <= FETCH;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        FETCH: begin
          mem_rd_en <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // Byte 0 is taken straight from the memory bus so it is ready on entry to STREAM.
          line       <= mem_rd_data[PAYLOAD_BYTES*8-1:0];
          next_idx_q <= ftr.next_idx;
          term       <= dec_term;
          last_ptr   <= dec_last_ptr;
          ptr        <= '0;
          err        <= (ftr.eop && cnt_bad) || forced;
          out_valid  <= 1'b1;
          out_data   <= mem_rd_data[7:0];
          out_sop    <= first;
          out_eop    <= dec_term && (dec_last_ptr == '0);
          state      <= STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            if (ptr == last_ptr) begin
              out_valid  <= 1'b0;
              out_sop    <= 1'b0;
              out_eop    <= 1'b0;
              first      <= 1'b0;
              free_valid <= 1'b1;
              free_idx   <= cur_idx;
              state      <= FREE;
            end else begin
              ptr      <= ptr_nxt;
              out_data <= line[{ptr_nxt, 3'b000} +: 8];
              out_sop  <= 1'b0;
              out_eop  <= term && (ptr_nxt == last_ptr);
            end
          end
        end
        FREE: begin
          if (free_ready) begin
            free_valid <= 1'b0;
            if (term) begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              cur_idx     <= next_idx_q;
              cell_cnt    <= cell_cnt + 1'b1;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= next_idx_q;
              state       <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cell_reader.md
CELL_READER -- requirements
Module: cell_reader

Interface
REQ-001 SHALL take parameter MAX_CELLS, default 32: maximum cells walked per packet before forced termination.
REQ-002 SHALL use the mem_pkg constants: BLOCK_BYTES=64, ADDR_W=12, PAYLOAD_BYTES=62, BLOCK_BITS=512, and footer_t.
REQ-003 SHALL have clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have cmd_valid/cmd_ready, in/out, 1/1: head-of-packet command handshake.
REQ-006 SHALL have cmd_head, input, ADDR_W: index of the first cell of the packet.
REQ-007 SHALL have mem_rd_en/mem_rd_addr, out/out, 1/ADDR_W: cell read request; data returns exactly 1 cycle later.
REQ-008 SHALL have mem_rd_data, input, BLOCK_BITS: the full cell; byte k is bits [8k+7:8k], and the footer_t is bits [511:496].
REQ-009 SHALL have out_valid/out_ready, out/in, 1/1: byte stream handshake.
REQ-010 SHALL have out_data, out_sop, out_eop, output, 8/1/1: payload byte, first-byte flag and last-byte flag.
REQ-011 SHALL have free_valid/free_ready/free_idx, out/in/out, 1/1/ADDR_W: return of a consumed cell to the free list.
REQ-012 SHALL have busy and err, output, 1/1: packet in progress; one-cycle error pulse.

Function
REQ-013 SHALL implement the states IDLE, FETCH, WAIT, STREAM and FREE.
REQ-014 IDLE: cmd_ready=1; on cmd_valid, SHALL latch cmd_head as cur_idx, clear the cell counter, set first=1, and go to FETCH.
REQ-015 FETCH: SHALL assert mem_rd_en=1 and mem_rd_addr=cur_idx for exactly one cycle, then go to WAIT.
REQ-016 WAIT: SHALL capture mem_rd_data into a BLOCK_BITS line register and decode the footer, then go to STREAM; the first byte is valid 3 cycles after the command is accepted.
REQ-017 Footer decode SHALL use these rules. If eop=0, the cell holds 62 valid bytes and next_idx is the next cell. If eop=1, next_idx[5:0] is the valid byte count, 1..62.
REQ-018 An eop cell whose count is 0 or greater than 62 SHALL be clamped to 62 and SHALL pulse err.
REQ-019 STREAM: SHALL present byte[ptr] on out_data with out_valid=1, and SHALL advance ptr only when out_valid&&out_ready.
REQ-020 out_sop SHALL be 1 only on byte 0 of the first cell.
REQ-021 out_eop SHALL be 1 only on the last valid byte of the terminating cell.
REQ-022 While out_valid=1 and out_ready=0, out_data/out_sop/out_eop SHALL hold stable.
REQ-023 When the last byte of a cell is accepted, SHALL go to FREE with free_idx=cur_idx.
REQ-024 FREE: SHALL hold free_valid=1 until free_ready. Then, for a terminating cell, SHALL go to IDLE; otherwise SHALL set cur_idx=next_idx, increment the cell counter, and go to FETCH.
REQ-025 A cell that is the MAX_CELLS-th of a packet with eop=0 SHALL be treated as terminating: 62 bytes, out_eop on byte 61, err pulsed in its WAIT cycle, next_idx ignored.
REQ-026 A cell with eop=1 and count=1 SHALL assert out_sop and out_eop on the same byte if it is also the first cell.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 A new command SHALL NOT be accepted until the current packet's final FREE handshake completes.
REQ-029 Each cell SHALL be freed exactly once, only after all of its bytes are accepted, in packet order.
REQ-030 out_valid, mem_rd_en and free_valid SHALL never be asserted combinationally from their own ready inputs.

Reset
REQ-031 On rst=1, SHALL go to IDLE with the reset values cmd_ready=0 during reset, mem_rd_en=0, out_valid=0, out_sop=0, out_eop=0, free_valid=0, err=0, busy=0, and indices/counters=0.
REQ-032 Reset mid-packet SHALL abandon the packet without freeing the in-flight cell; free-list reinitialisation is owned by the free-list block.

Structure
REQ-033 footer_t, PAYLOAD_BYTES and ADDR_W SHALL come from mem_pkg. The state enum and a localparam for the byte-count field width (6) SHALL be added to mem_pkg.
REQ-034 SHALL be a single module with no sub-module; the 62:1 byte select is inline.

Verification
REQ-035 Single cell: head=5 with footer {eop=1, next_idx=20}, out_ready=1 -> 20 bytes, sop on byte 0, eop on byte 19, free_idx=5, first byte 3 cycles after accept.
REQ-036 Three-cell chain 7->300->4095 ending with count=10, out_ready=1 -> 134 bytes in order, frees 7, 300, 4095 in order, one sop and one eop.
REQ-037 Random out_ready (50%) and free_ready stalls on REQ-036 -> identical byte sequence, outputs stable under stall, no duplicated or dropped free.
REQ-038 Count=0 and count=63 eop cells -> 62 bytes each, err pulsed once per cell.
REQ-039 Loop 9->9 with eop never set, MAX_CELLS=32 -> 1984 bytes, eop on the last, err pulsed once, 32 frees of index 9, returns to IDLE.
REQ-040 rst asserted mid-STREAM of cell 2 -> next cycle all outputs at reset values, idle, and a new command is accepted normally after rst is released.
